i2c_sda_engine: RTL

Bit-level SDA engine for the I2C master. Executes one bus command at a time (START, STOP, byte write with ACK check, byte read with ACK/NACK), and drives or samples SDA at fixed positions in each SCL period. It runs downstream of the SCL generator and uses that block's `count_ctrl` as its phase reference. The master FSM issues commands through a valid/ready handshake and consumes `done`, `ack_rcvd`, `rx_data` and `arb_lost`.

---
 rtl/i2c_sda_engine.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_sda_engine.sv
// Bit-level SDA engine for the I2C master.
// Runs one bus command at a time: START, STOP, byte WRITE with an ACK check,
// or byte READ that answers with ACK or NACK.
// SDA is driven or sampled at fixed phase points of the SCL generator's count_ctrl.
module i2c_sda_engine #(
  parameter int T_LOW  = 6,
  parameter int T_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic       cmd_ready,
  input  logic [7:0] tx_data,
  input  logic [6:0] count_ctrl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ack_rcvd,
  output logic       done,
  output logic       arb_lost,
  output logic       busy
);

  // Phase points within one SCL period (one slot).
  localparam logic [6:0] PH_DRV = 7'(T_LOW / 2);
  localparam logic [6:0] PH_SMP = 7'(T_LOW + T_HIGH / 2);
  localparam logic [6:0] PH_END = 7'(T_LOW + T_HIGH - 1);

  localparam logic [2:0] CMD_START     = 3'b001;
  localparam logic [2:0] CMD_STOP      = 3'b010;
  localparam logic [2:0] CMD_WRITE     = 3'b011;
  localparam logic [2:0] CMD_READ_ACK  = 3'b100;
  localparam logic [2:0] CMD_READ_NACK = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_START = 3'd2,
    ST_STOP  = 3'd3,
    ST_WR    = 3'd4,
    ST_RD    = 3'd5
  } state_t;

  state_t      state_r;
  logic [2:0]  pend_cmd_r;
  logic [7:0]  tx_shreg_r;
  logic [7:0]  rx_shreg_r;
  logic [3:0]  bit_cnt_r;
  logic        rd_ack_r;

  logic        at_zero_s;
  logic        at_drv_s;
  logic        at_smp_s;
  logic        at_end_s;
  logic        last_slot_s;

  // Only codes 001..101 are real commands; the rest are never accepted.
  function automatic logic cmd_legal(input logic [2:0] c);
    return (c >= CMD_START) && (c <= CMD_READ_NACK);
  endfunction

  // Working state that carries out a given command code.
  function automatic state_t cmd_state(input logic [2:0] c);
    case (c)
      CMD_START:     return ST_START;
      CMD_STOP:      return ST_STOP;
      CMD_WRITE:     return ST_WR;
      CMD_READ_ACK:  return ST_RD;
      CMD_READ_NACK: return ST_RD;
      default:       return ST_IDLE;
    endcase
  endfunction

  assign at_zero_s   = (count_ctrl == 7'd0);
  assign at_drv_s    = (count_ctrl == PH_DRV);
  assign at_smp_s    = (count_ctrl == PH_SMP);
  assign at_end_s    = (count_ctrl == PH_END);
  assign last_slot_s = (bit_cnt_r == 4'd8);

  // Command sequencer: accept, align to slot 0, run the slots, and pulse the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pend_cmd_r <= 3'b000;
      tx_shreg_r <= 8'h00;
      rx_shreg_r <= 8'h00;
      bit_cnt_r  <= 4'd0;
      rd_ack_r   <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      ack_rcvd   <= 1'b0;
      done       <= 1'b0;
      arb_lost   <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      arb_lost <= 1'b0;
      if (abort) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cmd_valid && cmd_legal(cmd)) begin
              pend_cmd_r <= cmd;
              tx_shreg_r <= tx_data;
              rd_ack_r   <= (cmd == CMD_READ_ACK);
              bit_cnt_r  <= 4'd0;
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              if (at_zero_s) begin
                // Slot 0 starts on the accept edge itself.
                state_r <= cmd_state(cmd);
                if (cmd == CMD_START) begin
                  sda_oe <= 1'b0;
                end
              end else begin
                state_r <= ST_ALIGN;
              end
            end
          end
          ST_ALIGN: begin
            if (at_zero_s) begin
              state_r <= cmd_state(pend_cmd_r);
              if (pend_cmd_r == CMD_START) begin
                sda_oe <= 1'b0;
              end
            end
          end
          ST_START: begin
            if (at_smp_s) begin
              sda_oe <= 1'b1;
            end
            if (at_end_s) begin
              state_r   <= ST_IDLE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
          ST_STOP: begin
            if (at_drv_s) begin
              sda_oe <= 1'b1;
            end
            if (at_smp_s) begin
              sda_oe <= 1'b0;
            end
            if (at_end_s) begin
              state_r   <= ST_IDLE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
          ST_WR: begin
            if (at_drv_s) begin
              sda_oe <= last_slot_s ? 1'b0 : ~tx_shreg_r[7];
            end
            if (at_smp_s && last_slot_s) begin
              ack_rcvd <= ~sda_in;
            end
            // Released SDA read back low means another master owns the bus.
            if (at_smp_s && !last_slot_s && !sda_oe && !sda_in) begin
              arb_lost  <= 1'b1;
              sda_oe    <= 1'b0;
              state_r   <= ST_IDLE;
              bit_cnt_r <= 4'd0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else if (at_end_s) begin
              if (last_slot_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end else begin
                tx_shreg_r <= {tx_shreg_r[6:0], 1'b0};
                bit_cnt_r  <= bit_cnt_r + 4'd1;
              end
            end
          end
          ST_RD: begin
            if (at_drv_s) begin
              sda_oe <= last_slot_s ? rd_ack_r : 1'b0;
            end
            if (at_smp_s && !last_slot_s) begin
              rx_shreg_r <= {rx_shreg_r[6:0], sda_in};
            end
            if (at_end_s) begin
              if (last_slot_s) begin
                sda_oe    <= 1'b0;
                rx_data   <= rx_shreg_r;
                rx_valid  <= 1'b1;
                done      <= 1'b1;
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            sda_oe    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
